// File: rtl/acc_pkg.sv
// Shared types and default sizing for the accumulator frame transmitter.
package acc_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam int DATA_W_DEF    = 6;
   localparam int BAUD_DIV_DEF  = 4;
   localparam int PARITY_EN_DEF = 1;
   localparam int NB            = DATA_W_DEF + 1;
   localparam int FRAME_BITS    = NB + 2 + PARITY_EN_DEF;

   // Serial bits per frame: start, carry+data, optional parity, stop.
   function automatic int frame_bits(input int data_w, input int parity_en);
      return data_w + 1 + 2 + parity_en;
   endfunction

endpackage

// File: rtl/acc_baud_gen.sv
// Bit-period down-counter: o_bit_tick marks the last clock of the current serial bit.
module acc_baud_gen
   import acc_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic clk,
   input  logic i_rst_n,
   input  logic i_load,
   output logic o_bit_tick
);

   localparam logic [7:0] RELOAD = 8'(BAUD_DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = RELOAD;
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_bit_tick = (cnt_q == 8'd0);

endmodule

// File: rtl/acc_frame_tx.sv
// Captures {carry, data} from the accumulator and sends it as a UART-style frame:
// start, data LSB first, optional even parity, stop. Counts words offered while busy.
module acc_frame_tx
   import acc_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BAUD_DIV  = BAUD_DIV_DEF,
   parameter int PARITY_EN = PARITY_EN_DEF,
   parameter int DROP_W    = 4
) (
   input  logic              clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_carry,
   input  logic              i_valid,
   output logic              o_ready,
   output logic              o_tx,
   output logic              o_busy,
   output logic              o_done,
   output logic [DROP_W-1:0] o_drop_cnt,
   output state_e            o_state
);

   localparam int NBITS = DATA_W + 1;
   localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBITS - 1);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   state_e             state_q, state_d;
   logic [NBITS-1:0]   shift_q, shift_d;
   logic               parity_q, parity_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               tx_q, tx_d;
   logic [DROP_W-1:0]  drop_q, drop_d;
   logic               load;
   logic               bit_tick;

   acc_baud_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk        (clk),
      .i_rst_n    (i_rst_n),
      .i_load     (load),
      .o_bit_tick (bit_tick)
   );

   // Handshake: a word is taken only on a cycle where i_valid && o_ready;
   // o_ready is high exactly while IDLE, so a held i_valid re-captures only after the frame.
   // tx_d is the line level for the state being entered, so o_tx is a clean flop output.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      idx_d    = idx_q;
      tx_d     = tx_q;
      load     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (i_valid) begin
               state_d  = START;
               shift_d  = {i_carry, i_data};
               parity_d = ^{i_carry, i_data};
               idx_d    = '0;
               tx_d     = 1'b0;
               load     = 1'b1;
            end
         end
         START: begin
            if (bit_tick) begin
               state_d = DATA;
               tx_d    = shift_q[0];
               load    = 1'b1;
            end
         end
         DATA: begin
            if (bit_tick) begin
               load = 1'b1;
               if (idx_q == LAST_IDX) begin
                  if (PARITY_EN != 0) begin
                     state_d = PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + IDX_W'(1);
                  tx_d    = shift_q[1];
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               state_d = STOP;
               tx_d    = 1'b1;
               load    = 1'b1;
            end
         end
         STOP: begin
            if (bit_tick) begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_comb begin
      drop_d = drop_q;
      if (i_valid && (state_q != IDLE) && (drop_q != DROP_MAX)) begin
         drop_d = drop_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         parity_q <= 1'b0;
         idx_q    <= '0;
         tx_q     <= 1'b1;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         idx_q    <= idx_d;
         tx_q     <= tx_d;
         drop_q   <= drop_d;
      end
   end

   assign o_ready    = (state_q == IDLE);
   assign o_busy     = (state_q != IDLE);
   assign o_done     = (state_q == STOP) && bit_tick;
   assign o_tx       = tx_q;
   assign o_drop_cnt = drop_q;
   assign o_state    = state_q;

endmodule

// File: doc/acc_frame_tx.md
Name: acc_frame_tx

Overview:
- Downstream stage of the unsigned accumulator. Captures the accumulator result (o_data plus o_carry) on a valid strobe.
- Serialises the captured word onto a single UART-style line: start bit, data LSB first, optional even parity, stop bit.
- Each bit is held for a programmable number of clocks.
- Exposes ready/busy/done status and a saturating count of words dropped while busy.

Parameters:
- DATA_W, 6, width of accumulator data input; transmitted word is DATA_W+1 bits (carry as MSB)
- BAUD_DIV, 4, clocks per serial bit; legal range 1..255
- PARITY_EN, 1, 1 = append even parity bit after data, 0 = omit it
- DROP_W, 4, width of saturating dropped-word counter

Ports:
- clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_data  input  DATA_W  accumulator result to send
- i_carry  input  1  accumulator carry; sent as bit DATA_W of the word
- i_valid  input  1  word present on i_data/i_carry this cycle
- o_ready  output  1  block is idle and will capture on i_valid
- o_tx  output  1  serial line, idle high
- o_busy  output  1  frame in progress
- o_done  output  1  one-cycle pulse at end of stop bit
- o_drop_cnt  output  DROP_W  count of i_valid cycles seen while not ready, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset i_rst_n is asynchronous, active-low.
  - During reset, with immediate effect: o_tx=1, o_ready=1, o_busy=0, o_done=0, o_drop_cnt=0, state=IDLE.
  - All internal counters clear.
- Word: W = {i_carry, i_data}, NB = DATA_W+1 bits, captured into a shift register.
- Parity: P = XOR of all NB bits of W (even parity).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_ready=1, o_busy=0, o_tx=1.
  - i_valid=1 at edge k: capture W, go to START.
  - o_tx=0 and o_busy=1 from edge k onward (registered outputs).
- Bit timing: every state except IDLE lasts exactly BAUD_DIV clocks. A baud counter reloads on each state entry.
- START: o_tx=0, then go to DATA.
- DATA:
  - o_tx = shift_reg[0]; shift right at each bit boundary.
  - A bit index counts 0..NB-1; after bit NB-1, go to PARITY if PARITY_EN else STOP.
- PARITY: o_tx=P, then go to STOP.
- STOP:
  - o_tx=1.
  - On the final clock of STOP, o_done=1 for exactly one cycle, then go to IDLE.
- Frame length: (NB+2+PARITY_EN)*BAUD_DIV clocks. Default is 10 bits, 40 clocks.
- o_ready is 1 only in IDLE. Minimum spacing between captures is the frame length plus one IDLE cycle.
- Handshake:
  - Capture occurs only when i_valid && o_ready.
  - i_data and i_carry are don't-care when i_valid=0.
  - i_valid held high across a frame does not re-capture until IDLE is reached.
- Drop counter:
  - Each cycle with i_valid=1 && o_ready=0 increments o_drop_cnt.
  - Holds at 2^DROP_W-1 and never wraps. Cleared only by reset.
- Input changes mid-frame have no effect on the frame in progress; the shift register is isolated.
- Reset mid-frame: the frame is aborted, o_tx returns to 1 immediately, and no o_done is issued.
- BAUD_DIV=1: each bit lasts one clock, and there are no extra idle cycles inside the frame.

Decomposition:
- Shared package acc_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - localparams NB=DATA_W+1 and FRAME_BITS=NB+2+PARITY_EN
  - default BAUD_DIV
- One sub-module, acc_baud_gen: a down-counter with load and bit_tick output, reloaded on state entry. Everything else stays in acc_frame_tx.

Test Plan:
- Reset values: hold i_rst_n=0 for 10 clocks, then release. Required: o_tx=1, o_ready=1, o_busy=0, o_done=0, o_drop_cnt=0.
- Data 20, no carry: i_data=20, i_carry=0, one-cycle i_valid.
  - o_tx bit sequence, each bit 4 clocks: 0 | 0,0,1,0,1,0,0 | P=0 | 1.
  - o_done pulses 40 clocks after capture; o_ready returns 1 on the next cycle.
- All ones with carry: i_data=63, i_carry=1. Required: data bits all 1, P=1, stop 1, frame length 40 clocks.
- Drop counting: pulse i_valid 3 times mid-frame, each with different data.
  - Frame content unchanged, o_drop_cnt=3.
  - Then hold i_valid high through 3 frames: o_drop_cnt saturates at 15.
- Reset mid-frame: assert i_rst_n=0 during the DATA state.
  - o_tx=1 and o_busy=0 asynchronously, no o_done.
  - After release, a new word sends a correct full frame.
- Parameter corner: PARITY_EN=0, BAUD_DIV=1, data 20.
  - 9-clock frame 0,0,0,1,0,1,0,0,1.
  - Back-to-back i_valid held high gives captures 10 clocks apart.
